// File: rtl/painel_varredura.sv
// ============================================================================
// Module      : painel_varredura
// Description : Column-scan and double-buffered frame controller for a 5x7
//               LED panel. It feeds the row demux bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module painel_varredura #(
  parameter int CLK_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [34:0] load_data,
  input  logic        scroll_en,
  output logic        sel1,
  output logic        sel2,
  output logic        sel3,
  output logic [6:0]  outRU0,
  output logic [6:0]  outRU1,
  output logic [6:0]  outRU2,
  output logic [6:0]  outRU3,
  output logic [6:0]  outRU4,
  output logic        frame_start
);

  localparam logic [15:0] c_PRESC_MAX = 16'(CLK_DIV - 1);
  localparam logic [2:0]  c_COL_LAST  = 3'd6;

  localparam logic [0:0]  c_EMPTY     = 1'b0;
  localparam logic [0:0]  c_PENDING   = 1'b1;

  logic [15:0] r_prescaler;
  logic [2:0]  r_col;
  logic        r_frameStart;
  logic [0:0]  r_state;
  logic [34:0] r_shadow;
  logic [34:0] r_active;

  logic        w_tick;
  logic        w_boundary;
  logic [34:0] w_rotated;

  assign w_tick     = (r_prescaler == c_PRESC_MAX);
  assign w_boundary = w_tick && (r_col == c_COL_LAST);

  // Each 7-bit row rotates left by one column: new[c] = old[c-1], new[0] = old[6].
  for (genvar r = 0; r < 5; r++) begin : g_rot
    assign w_rotated[7*r +: 7] = {r_active[7*r +: 6], r_active[7*r + 6]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescaler  <= '0;
      r_col        <= '0;
      r_frameStart <= 1'b0;
    end else begin
      r_prescaler  <= w_tick ? '0 : r_prescaler + 16'd1;
      r_frameStart <= w_boundary;
      if (w_tick) begin
        r_col <= (r_col == c_COL_LAST) ? 3'd0 : r_col + 3'd1;
      end
    end
  end

  // A load accepted on a boundary edge lands in PENDING and waits for the next wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_EMPTY;
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      case (r_state)
        c_EMPTY: begin
          if (load_valid) begin
            r_shadow <= load_data;
            r_state  <= c_PENDING;
          end
          if (w_boundary && scroll_en) begin
            r_active <= w_rotated;
          end
        end
        c_PENDING: begin
          if (w_boundary) begin
            r_active <= r_shadow;
            r_state  <= c_EMPTY;
          end
        end
        default: r_state <= c_EMPTY;
      endcase
    end
  end

  assign load_ready  = (r_state == c_EMPTY);
  assign sel1        = r_col[0];
  assign sel2        = r_col[1];
  assign sel3        = r_col[2];
  assign frame_start = r_frameStart;
  assign outRU0      = r_active[6:0];
  assign outRU1      = r_active[13:7];
  assign outRU2      = r_active[20:14];
  assign outRU3      = r_active[27:21];
  assign outRU4      = r_active[34:28];

endmodule

`default_nettype wire

// File: doc/painel_varredura.md
Name: painel_varredura

Overview:
- Column-scan and frame-buffer controller for the 5x7 LED electronic panel; sits directly upstream of the row demultiplexer bank.
- Drives the five 7-bit row words (outRU0..outRU4) and the 3-bit column select (sel1..sel3) that the demux bank consumes.
- Accepts new frames over a valid/ready handshake and double-buffers them so a frame never changes mid-scan.
- Optionally scrolls the displayed frame left by one column per full scan.

Parameters:
- CLK_DIV, 1000, clock cycles spent on each column; legal range 1..65535.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  a new frame is offered on load_data.
- load_ready  output  1  shadow buffer is empty and a frame can be accepted.
- load_data  input  35  frame data; row r occupies bits [7r+6:7r]; bit c of a row is column c.
- scroll_en  input  1  enables the one-column left rotation at each frame boundary.
- sel1  output  1  column select bit 0 (LSB).
- sel2  output  1  column select bit 1.
- sel3  output  1  column select bit 2 (MSB).
- outRU0..outRU4  output  7 each  active frame rows 0..4, fed to the demux bank.
- frame_start  output  1  one-cycle pulse when the column index wraps to 0.

Behaviour:
- Everything is registered on the rising edge of clk. rst clears all state immediately, with no clock needed.
- Reset values: col=0 so {sel3,sel2,sel1}=000; prescaler=0; outRU0..4=0; shadow EMPTY so load_ready=1; frame_start=0.
- Prescaler:
  - Counts 0..CLK_DIV-1.
  - The "tick" condition is prescaler==CLK_DIV-1. On a tick, the prescaler returns to 0 and col advances.
  - With CLK_DIV=1, a tick occurs every cycle.
- Column counter:
  - Counts 0..6 on ticks; 6 wraps to 0. Values 7 never occur.
  - {sel3,sel2,sel1} always equals col.
- Frame boundary:
  - Defined as a tick while col==6.
  - On the edge that takes col from 6 to 0, frame_start is registered high for exactly one cycle.
- Shadow buffer FSM, states EMPTY and PENDING:
  - EMPTY: load_ready=1. If load_valid=1, capture load_data into the shadow and move to PENDING.
  - PENDING: load_ready=0; load_valid is ignored. At a frame boundary, copy the shadow into the active rows and move to EMPTY.
- Frame-boundary update priority, decided on the boundary edge using the pre-edge state:
  1. PENDING: the active rows take the shadow contents and scroll is skipped for this boundary.
  2. Otherwise, if scroll_en=1: each row rotates left by one, so new[c]=old[c-1] for c=1..6 and new[0]=old[6].
  3. Otherwise: the active rows hold their value.
- Simultaneous events:
  - A load accepted on the boundary edge itself (state was EMPTY) is not displayed at that boundary. It becomes PENDING and is displayed at the next boundary.
  - scroll_en is sampled only at boundaries; changes between boundaries have no effect.
- The active rows change only at frame boundaries, so there is no tearing within a scan.
- Reset mid-operation: a pending frame is discarded and the outputs return to their reset values immediately.

Test Plan:
- Reset: with CLK_DIV=2, assert rst asynchronously mid-cycle -> sel=000, all outRU=0, load_ready=1, frame_start=0 with no clock edge.
- Scan timing: with CLK_DIV=2, release reset -> sel steps 0,1,...,6,0 every 2 cycles, and frame_start pulses once, one cycle wide, every 14 cycles.
- Load handshake:
  - Offer load_data with row0=7'b0000001 and other rows 0 -> accepted in one cycle, then load_ready=0.
  - outRU0 stays 0 until the next 6->0 wrap, then becomes 0000001 and load_ready returns to 1.
- Scroll: with the frame above and scroll_en=1 -> outRU0 reads 0000010, 0000100, ..., 1000000, 0000001 at successive boundaries (wrap-around).
- Priority: assert scroll_en=1 while a frame is PENDING at a boundary -> the shadow frame is displayed unrotated, and rotation resumes at the following boundary.
- Boundary-edge load: assert load_valid on exactly the col==6 tick cycle while EMPTY -> the frame is not shown at that wrap; it is shown at the next wrap, 14 cycles later with CLK_DIV=2.
